// File: rtl/vclock_ranker.sv
// vclock_ranker
//   Dual-slot Virtual Clock start-tag rank computer feeding a two-push
//   scheduler. Each cycle up to two arrivals are admitted (or dropped when
//   the flow ID is not one-hot or the flow already has MAX_OUT packets
//   outstanding). Each admitted arrival gets rank = max(now, last_finish[f]).
//   The flow's finish tag then advances by len << shift[f], saturating at
//   32'hFFFF_FFFF. Scheduler dequeues reported on deq_* retire outstanding
//   packets one cycle later.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   in_valid/value/flow/len_1,2 arrival slots (flow is one-hot)
//   cfg_we, cfg_flow, cfg_shift per-flow rate shift write (effective next cycle)
//   deq_valid, deq_flow         scheduler pop observation
//   push_*, push_rank/value/flow_*  registered push to the scheduler (1-cycle latency)
//   drop_1, drop_2              registered reject pulse per slot
//   now                         free-running saturating time counter
//
// Handshake: there is no backpressure. An arrival is a single-cycle
// in_valid_k pulse. Exactly one of push_k / drop_k pulses for it one cycle
// later. Slot k in always maps to slot k out.
module vclock_ranker #(
  parameter int FLOWS   = 10,
  parameter int MAX_OUT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_1,
  input  logic             in_valid_2,
  input  logic [31:0]      in_value_1,
  input  logic [31:0]      in_value_2,
  input  logic [FLOWS-1:0] in_flow_1,
  input  logic [FLOWS-1:0] in_flow_2,
  input  logic [15:0]      in_len_1,
  input  logic [15:0]      in_len_2,
  input  logic             cfg_we,
  input  logic [FLOWS-1:0] cfg_flow,
  input  logic [3:0]       cfg_shift,
  input  logic             deq_valid,
  input  logic [FLOWS-1:0] deq_flow,
  output logic             push_1,
  output logic             push_2,
  output logic [31:0]      push_rank_1,
  output logic [31:0]      push_rank_2,
  output logic [31:0]      push_value_1,
  output logic [31:0]      push_value_2,
  output logic [FLOWS-1:0] push_flow_1,
  output logic [FLOWS-1:0] push_flow_2,
  output logic             drop_1,
  output logic             drop_2,
  output logic [31:0]      now
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW:0] CAP = (CW+1)'(MAX_OUT);

  function automatic logic is_onehot(logic [FLOWS-1:0] v);
    return (v != '0) && ((v & (v - FLOWS'(1))) == '0);
  endfunction

  function automatic logic [31:0] max32(logic [31:0] a, logic [31:0] b);
    return (a > b) ? a : b;
  endfunction

  // 33-bit add so any carry out saturates the tag instead of wrapping.
  function automatic logic [31:0] sat_finish(logic [31:0] start, logic [15:0] len,
                                             logic [3:0] sh);
    logic [31:0] inc;
    logic [32:0] sum;
    inc = {16'd0, len} << sh;
    sum = {1'b0, start} + {1'b0, inc};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

  // Per-flow state
  logic [31:0]   now_q;
  logic [31:0]   last_finish_q [FLOWS];
  logic [31:0]   last_finish_d [FLOWS];
  logic [3:0]    shift_q       [FLOWS];
  logic [3:0]    shift_d       [FLOWS];
  logic [CW-1:0] count_q       [FLOWS];
  logic [CW-1:0] count_d       [FLOWS];

  // Output registers
  logic             push_1_q, push_2_q, drop_1_q, drop_2_q;
  logic [31:0]      rank_1_q, rank_2_q, value_1_q, value_2_q;
  logic [FLOWS-1:0] flow_1_q, flow_2_q;

  // Per-slot lookups
  logic [31:0]   lf_1, lf_2;
  logic [3:0]    sh_1, sh_2;
  logic [CW-1:0] cnt_1, cnt_2;
  logic          acc_1, acc_2, deq_ok;
  logic [31:0]   start_1, start_2, fin_1, fin_2, base_2;

  // One-hot flow IDs make an OR-reduction a plain mux. Multi-hot lookups
  // produce junk, but those arrivals are dropped anyway.
  always_comb begin
    lf_1  = '0;
    lf_2  = '0;
    sh_1  = '0;
    sh_2  = '0;
    cnt_1 = '0;
    cnt_2 = '0;
    for (int f = 0; f < FLOWS; f++) begin
      if (in_flow_1[f]) begin
        lf_1  = lf_1  | last_finish_q[f];
        sh_1  = sh_1  | shift_q[f];
        cnt_1 = cnt_1 | count_q[f];
      end
      if (in_flow_2[f]) begin
        lf_2  = lf_2  | last_finish_q[f];
        sh_2  = sh_2  | shift_q[f];
        cnt_2 = cnt_2 | count_q[f];
      end
    end
  end

  always_comb begin
    acc_1   = in_valid_1 && is_onehot(in_flow_1) && ({1'b0, cnt_1} < CAP);
    start_1 = max32(now_q, lf_1);
    fin_1   = sat_finish(start_1, in_len_1, sh_1);
    // Slot 2 on the same flow sees slot 1 as already admitted: it occupies
    // one more outstanding place and its finish tag is the new baseline.
    acc_2   = in_valid_2 && is_onehot(in_flow_2) &&
              (({1'b0, cnt_2} + {{CW{1'b0}}, acc_1 && (in_flow_1 == in_flow_2)}) < CAP);
    base_2  = (acc_1 && (in_flow_1 == in_flow_2)) ? fin_1 : lf_2;
    start_2 = max32(now_q, base_2);
    fin_2   = sat_finish(start_2, in_len_2, sh_2);
    deq_ok  = deq_valid && is_onehot(deq_flow);
  end

  always_comb begin
    for (int f = 0; f < FLOWS; f++) begin
      last_finish_d[f] = last_finish_q[f];
      shift_d[f]       = shift_q[f];
      count_d[f]       = count_q[f] + CW'(acc_1 && in_flow_1[f]) + CW'(acc_2 && in_flow_2[f])
                         - CW'(deq_ok && deq_flow[f] && (count_q[f] != '0));
      // Slot 2 is later in arrival order, so its finish tag wins.
      if (acc_1 && in_flow_1[f]) last_finish_d[f] = fin_1;
      if (acc_2 && in_flow_2[f]) last_finish_d[f] = fin_2;
      if (cfg_we && cfg_flow[f]) shift_d[f] = cfg_shift;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      now_q     <= '0;
      push_1_q  <= 1'b0;
      push_2_q  <= 1'b0;
      drop_1_q  <= 1'b0;
      drop_2_q  <= 1'b0;
      rank_1_q  <= '0;
      rank_2_q  <= '0;
      value_1_q <= '0;
      value_2_q <= '0;
      flow_1_q  <= '0;
      flow_2_q  <= '0;
      for (int f = 0; f < FLOWS; f++) begin
        last_finish_q[f] <= '0;
        shift_q[f]       <= '0;
        count_q[f]       <= '0;
      end
    end else begin
      now_q     <= (now_q == 32'hFFFF_FFFF) ? now_q : now_q + 32'd1;
      push_1_q  <= acc_1;
      push_2_q  <= acc_2;
      drop_1_q  <= in_valid_1 && !acc_1;
      drop_2_q  <= in_valid_2 && !acc_2;
      rank_1_q  <= start_1;
      rank_2_q  <= start_2;
      value_1_q <= in_value_1;
      value_2_q <= in_value_2;
      flow_1_q  <= in_flow_1;
      flow_2_q  <= in_flow_2;
      for (int f = 0; f < FLOWS; f++) begin
        last_finish_q[f] <= last_finish_d[f];
        shift_q[f]       <= shift_d[f];
        count_q[f]       <= count_d[f];
      end
    end
  end

  assign push_1       = push_1_q;
  assign push_2       = push_2_q;
  assign drop_1       = drop_1_q;
  assign drop_2       = drop_2_q;
  assign push_rank_1  = rank_1_q;
  assign push_rank_2  = rank_2_q;
  assign push_value_1 = value_1_q;
  assign push_value_2 = value_2_q;
  assign push_flow_1  = flow_1_q;
  assign push_flow_2  = flow_2_q;
  assign now          = now_q;

endmodule

// File: tb/tb_vclock_ranker.sv
// Testbench for vclock_ranker (FLOWS=4, MAX_OUT=2). Directed scenarios,
// then randomized traffic, all checked against a sequential per-arrival
// model of the Virtual Clock rules.
module tb_vclock_ranker;

  localparam int FL = 4;
  localparam int MO = 2;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT inputs
  logic          in_valid_1, in_valid_2;
  logic [31:0]   in_value_1, in_value_2;
  logic [FL-1:0] in_flow_1, in_flow_2;
  logic [15:0]   in_len_1, in_len_2;
  logic          cfg_we;
  logic [FL-1:0] cfg_flow;
  logic [3:0]    cfg_shift;
  logic          deq_valid;
  logic [FL-1:0] deq_flow;

  // DUT outputs
  logic          push_1, push_2, drop_1, drop_2;
  logic [31:0]   push_rank_1, push_rank_2, push_value_1, push_value_2, now;
  logic [FL-1:0] push_flow_1, push_flow_2;

  vclock_ranker #(.FLOWS(FL), .MAX_OUT(MO)) dut (
    .clk(clk), .rst(rst),
    .in_valid_1(in_valid_1), .in_valid_2(in_valid_2),
    .in_value_1(in_value_1), .in_value_2(in_value_2),
    .in_flow_1(in_flow_1), .in_flow_2(in_flow_2),
    .in_len_1(in_len_1), .in_len_2(in_len_2),
    .cfg_we(cfg_we), .cfg_flow(cfg_flow), .cfg_shift(cfg_shift),
    .deq_valid(deq_valid), .deq_flow(deq_flow),
    .push_1(push_1), .push_2(push_2),
    .push_rank_1(push_rank_1), .push_rank_2(push_rank_2),
    .push_value_1(push_value_1), .push_value_2(push_value_2),
    .push_flow_1(push_flow_1), .push_flow_2(push_flow_2),
    .drop_1(drop_1), .drop_2(drop_2),
    .now(now)
  );

  // Scoreboard counters
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  longint unsigned m_lf  [FL];
  int              m_sh  [FL];
  int              m_cnt [FL];
  longint unsigned m_now;

  function automatic int idx_of(input logic [FL-1:0] f);
    int hits = 0;
    int idx  = -1;
    for (int i = 0; i < FL; i++) if (f[i]) begin hits++; idx = i; end
    return (hits == 1) ? idx : -1;
  endfunction

  // Arrivals are processed one at a time in slot order, so a same-flow slot 2
  // naturally sees slot 1's updated finish tag and outstanding count.
  task automatic arrive(input logic v, input logic [FL-1:0] f, input logic [15:0] len,
                        output logic p, output logic d, output logic [31:0] r);
    int i;
    longint unsigned st, fin;
    p = 1'b0; d = 1'b0; r = '0;
    if (v) begin
      i = idx_of(f);
      if (i < 0 || m_cnt[i] >= MO) d = 1'b1;
      else begin
        st  = (m_now > m_lf[i]) ? m_now : m_lf[i];
        fin = st + (longint'(len) << m_sh[i]);
        if (fin > 64'hFFFF_FFFF) fin = 64'hFFFF_FFFF;
        r = st[31:0];
        m_lf[i] = fin;
        m_cnt[i]++;
        p = 1'b1;
      end
    end
  endtask

  // Advance one clock: predict, clock, compare.
  task automatic step();
    logic          e_p1, e_p2, e_d1, e_d2;
    logic [31:0]   e_r1, e_r2, e_v1, e_v2;
    logic [FL-1:0] e_f1, e_f2;
    int            di;
    logic          deq_hit;
    if (rst) begin
      {e_p1, e_p2, e_d1, e_d2} = '0;
      {e_r1, e_r2, e_v1, e_v2} = '0;
      e_f1 = '0; e_f2 = '0;
      for (int i = 0; i < FL; i++) begin m_lf[i] = 0; m_sh[i] = 0; m_cnt[i] = 0; end
      m_now = 0;
    end else begin
      di      = idx_of(deq_flow);
      deq_hit = deq_valid && (di >= 0) && (m_cnt[(di < 0) ? 0 : di] > 0);
      arrive(in_valid_1, in_flow_1, in_len_1, e_p1, e_d1, e_r1);
      arrive(in_valid_2, in_flow_2, in_len_2, e_p2, e_d2, e_r2);
      if (deq_hit) m_cnt[di]--;
      if (cfg_we) for (int i = 0; i < FL; i++) if (cfg_flow[i]) m_sh[i] = int'(cfg_shift);
      e_v1 = in_value_1; e_v2 = in_value_2;
      e_f1 = in_flow_1;  e_f2 = in_flow_2;
      if (m_now < 64'hFFFF_FFFF) m_now++;
    end
    @(posedge clk);
    #1;
    check_val("push_1", push_1, e_p1);
    check_val("push_2", push_2, e_p2);
    check_val("drop_1", drop_1, e_d1);
    check_val("drop_2", drop_2, e_d2);
    check_val("now", now, m_now[31:0]);
    if (rst || e_p1) begin
      check_val("rank_1", push_rank_1, e_r1);
      check_val("value_1", push_value_1, e_v1);
      check_val("flow_1", 32'(push_flow_1), 32'(e_f1));
    end
    if (rst || e_p2) begin
      check_val("rank_2", push_rank_2, e_r2);
      check_val("value_2", push_value_2, e_v2);
      check_val("flow_2", 32'(push_flow_2), 32'(e_f2));
    end
  endtask

  // Driver tasks
  task automatic clear_inputs();
    in_valid_1 = 0; in_valid_2 = 0;
    in_value_1 = $urandom; in_value_2 = $urandom;
    in_flow_1 = '0; in_flow_2 = '0;
    in_len_1 = '0; in_len_2 = '0;
    cfg_we = 0; cfg_flow = '0; cfg_shift = '0;
    deq_valid = 0; deq_flow = '0;
  endtask

  task automatic set_slot1(input logic [FL-1:0] f, input logic [15:0] len);
    in_valid_1 = 1; in_flow_1 = f; in_len_1 = len;
  endtask

  task automatic set_slot2(input logic [FL-1:0] f, input logic [15:0] len);
    in_valid_2 = 1; in_flow_2 = f; in_len_2 = len;
  endtask

  task automatic set_cfg(input logic [FL-1:0] f, input logic [3:0] sh);
    cfg_we = 1; cfg_flow = f; cfg_shift = sh;
  endtask

  task automatic set_deq(input logic [FL-1:0] f);
    deq_valid = 1; deq_flow = f;
  endtask

  function automatic logic [FL-1:0] rand_flow();
    int r = $urandom_range(0, 9);
    if (r == 0) return '0;
    if (r == 1) return FL'($urandom_range(0, (1 << FL) - 1));
    return FL'(1) << $urandom_range(0, FL - 1);
  endfunction

  logic [15:0] fill_len;

  initial begin
    clear_inputs();
    rst = 1;
    step();
    step();
    check_val("reset_now", now, 32'd0);
    rst = 0;

    // Single arrival and latency
    for (int k = 0; k < 20 && m_now < 5; k++) begin clear_inputs(); step(); end
    clear_inputs(); set_slot1(4'b0001, 16'd100); step();
    check_val("single_push", push_1, 1'b1);
    check_val("single_rank", push_rank_1, 32'd5);
    clear_inputs(); set_slot1(4'b0001, 16'd100); step();
    check_val("second_rank", push_rank_1, 32'd105);
    clear_inputs(); set_deq(4'b0001); step(); step();

    // Same-flow dual arrival
    clear_inputs(); set_cfg(4'b0010, 4'd2); step();
    for (int k = 0; k < 20 && m_now < 10; k++) begin clear_inputs(); step(); end
    clear_inputs(); set_slot1(4'b0010, 16'd8); set_slot2(4'b0010, 16'd4); step();
    check_val("dual_rank_1", push_rank_1, 32'd10);
    check_val("dual_rank_2", push_rank_2, 32'd42);
    clear_inputs(); set_deq(4'b0010); step(); step();
    clear_inputs(); set_slot1(4'b0010, 16'd0); step();
    check_val("dual_last_finish", push_rank_1, 32'd58);
    clear_inputs(); set_deq(4'b0010); step();

    // Per-flow cap
    clear_inputs(); set_slot1(4'b0100, 16'd1); set_slot2(4'b0100, 16'd1); step();
    clear_inputs(); set_slot1(4'b0100, 16'd1); step();
    check_val("cap_drop", drop_1, 1'b1);
    check_val("cap_nopush", push_1, 1'b0);
    clear_inputs(); set_deq(4'b0100); set_slot1(4'b0100, 16'd1); step();
    check_val("cap_same_cycle_drop", drop_1, 1'b1);
    clear_inputs(); set_slot1(4'b0100, 16'd1); step();
    check_val("cap_after_deq_push", push_1, 1'b1);

    // Invalid flow IDs, then slot-1 drop beside slot-2 accept
    clear_inputs(); set_slot1(4'b0000, 16'd3); set_slot2(4'b0101, 16'd3); step();
    check_val("inv_drop_1", drop_1, 1'b1);
    check_val("inv_drop_2", drop_2, 1'b1);
    clear_inputs(); set_slot1(4'b0100, 16'd2); set_slot2(4'b1000, 16'd5); step();
    check_val("mixed_push_1", push_1, 1'b0);
    check_val("mixed_push_2", push_2, 1'b1);
    clear_inputs(); set_deq(4'b0100); step(); step();
    clear_inputs(); set_deq(4'b1000); step();

    // Saturation on flow 3: build last_finish up to 32'hFFFF_FF00
    clear_inputs(); set_cfg(4'b1000, 4'd15); step();
    clear_inputs(); set_deq(4'b1000); set_slot1(4'b1000, 16'hFFFF); step();
    clear_inputs(); set_deq(4'b1000); set_slot1(4'b1000, 16'hFFFF); step();
    clear_inputs(); set_deq(4'b1000); set_cfg(4'b1000, 4'd0); step();
    fill_len = 16'(64'hFFFF_FF00 - m_lf[3]);
    clear_inputs(); set_deq(4'b1000); set_slot1(4'b1000, fill_len); step();
    clear_inputs(); set_deq(4'b1000); set_cfg(4'b1000, 4'd15); step();
    clear_inputs(); set_deq(4'b1000); set_slot1(4'b1000, 16'hFFFF); step();
    check_val("sat_rank", push_rank_1, 32'hFFFF_FF00);
    clear_inputs(); set_deq(4'b1000); set_slot1(4'b1000, 16'd1); step();
    check_val("sat_rank_next", push_rank_1, 32'hFFFF_FFFF);
    clear_inputs(); set_deq(4'b1000); step();

    // Reset mid-stream
    clear_inputs(); set_slot1(4'b0001, 16'd3); set_slot2(4'b0010, 16'd3); step();
    rst = 1;
    clear_inputs(); set_slot1(4'b0001, 16'd3); set_slot2(4'b0010, 16'd3); step();
    check_val("midrst_push_1", push_1, 1'b0);
    check_val("midrst_now", now, 32'd0);
    rst = 0;
    clear_inputs(); set_slot1(4'b0001, 16'd7); step();
    check_val("postrst_rank", push_rank_1, 32'd0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      clear_inputs();
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 2) != 0) set_slot1(rand_flow(), 16'($urandom_range(0, 200)));
      if ($urandom_range(0, 2) != 0) set_slot2(rand_flow(), 16'($urandom_range(0, 200)));
      if ($urandom_range(0, 9) == 0) set_cfg(rand_flow(), 4'($urandom_range(0, 4)));
      if ($urandom_range(0, 1) == 0) set_deq(rand_flow());
      step();
    end
    rst = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
